// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory: funct3 encodings,
// controller states and access-size decode.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  // funct3[1:0] encodes log2 of the access size for every legal encoding.
  function automatic logic [3:0] access_bytes(input logic [2:0] f3);
    return 4'd1 << f3[1:0];
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for the data memory: store enables/data, fault decode,
// and load extraction with sign or zero extension.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]                       i_funct3,
  input  logic                             i_write,
  input  logic [$clog2(DATA_WIDTH/8)-1:0]  i_offset,
  input  logic [DATA_WIDTH-1:0]            i_wdata,
  input  logic [DATA_WIDTH-1:0]            i_rword,
  output logic [DATA_WIDTH/8-1:0]          o_be,
  output logic [DATA_WIDTH-1:0]            o_wdata,
  output logic                             o_fault,
  output logic [DATA_WIDTH-1:0]            o_rdata
);

  localparam int NB = DATA_WIDTH / 8;

  logic [3:0]            w_size;
  logic [3:0]            w_off;
  logic [7:0]            w_mask;
  logic                  w_illegal;
  logic                  w_misalign;
  logic [DATA_WIDTH-1:0] w_shift;

  assign w_size = access_bytes(i_funct3);
  assign w_off  = 4'(i_offset);

  // Doubleword and LWU only exist on a 64-bit array; 111 never exists.
  assign w_illegal = (i_funct3 == 3'b111) || (i_write && i_funct3[2]) ||
                     ((DATA_WIDTH == 32) && ((i_funct3 == F3_D) || (i_funct3 == F3_WU)));
  assign w_misalign = (w_off & (w_size - 4'd1)) != 4'd0;
  assign o_fault    = w_illegal || w_misalign;

  assign w_mask  = 8'((9'd1 << w_size) - 9'd1);
  assign o_be    = o_fault ? '0 : NB'(NB'(w_mask) << w_off);
  assign o_wdata = i_wdata << {i_offset, 3'b000};
  assign w_shift = i_rword >> {i_offset, 3'b000};

  always_comb begin
    o_rdata = '0;
    if (!o_fault && !i_write) begin
      case (i_funct3)
        F3_B:    o_rdata = DATA_WIDTH'($signed(w_shift[7:0]));
        F3_H:    o_rdata = DATA_WIDTH'($signed(w_shift[15:0]));
        F3_W:    o_rdata = DATA_WIDTH'($signed(w_shift[31:0]));
        F3_D:    o_rdata = w_shift;
        F3_BU:   o_rdata = DATA_WIDTH'(w_shift[7:0]);
        F3_HU:   o_rdata = DATA_WIDTH'(w_shift[15:0]);
        F3_WU:   o_rdata = DATA_WIDTH'(w_shift[31:0]);
        default: o_rdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/data_memory_hs.sv
// Data memory with valid/ready request and response handshakes, RISC-V
// load/store sizing, fault flagging and a configurable read latency.
module data_memory_hs
  import dmem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 12,
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [2:0]            funct3,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  resp_fault
);

  localparam int NB    = DATA_WIDTH / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int DEPTH = (2 ** ADDR_WIDTH) / NB;

  if (!((DATA_WIDTH == 32) || (DATA_WIDTH == 64))) begin : g_bad_width
    $error("data_memory_hs: DATA_WIDTH must be 32 or 64");
  end
  if ((READ_LATENCY < 1) || (READ_LATENCY > 4)) begin : g_bad_latency
    $error("data_memory_hs: READ_LATENCY must be within 1..4");
  end

  logic [DATA_WIDTH-1:0]       r_mem [DEPTH];
  state_t                      r_state;
  logic [1:0]                  r_cnt;
  logic                        r_req_ready;
  logic                        r_resp_valid;
  logic                        r_resp_fault;
  logic [DATA_WIDTH-1:0]       r_data_out;

  logic [ADDR_WIDTH-OFF_W-1:0] w_idx;
  logic [OFF_W-1:0]            w_off;
  logic [DATA_WIDTH-1:0]       w_rword;
  logic [NB-1:0]               w_be;
  logic [DATA_WIDTH-1:0]       w_wdata;
  logic                        w_fault;
  logic [DATA_WIDTH-1:0]       w_rdata;
  logic                        w_accept;

  assign w_idx    = address[ADDR_WIDTH-1:OFF_W];
  assign w_off    = address[OFF_W-1:0];
  assign w_rword  = r_mem[w_idx];
  assign w_accept = req_valid && r_req_ready;

  dmem_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .i_funct3 (funct3),
    .i_write  (req_write),
    .i_offset (w_off),
    .i_wdata  (data_in),
    .i_rword  (w_rword),
    .o_be     (w_be),
    .o_wdata  (w_wdata),
    .o_fault  (w_fault),
    .o_rdata  (w_rdata)
  );

  // Faulting stores arrive with all byte enables cleared, so they never write.
  always_ff @(posedge clock) begin
    if (reset_n && w_accept && req_write) begin
      for (int b = 0; b < NB; b++) begin
        if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= IDLE;
      r_cnt        <= 2'd0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_resp_fault <= 1'b0;
      r_data_out   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_data_out   <= w_rdata;
            r_resp_fault <= w_fault;
            r_req_ready  <= 1'b0;
            if (READ_LATENCY == 1) begin
              r_state      <= RESP;
              r_resp_valid <= 1'b1;
            end else begin
              r_state <= WAIT;
              r_cnt   <= 2'(READ_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 2'd1;
          if (r_cnt == 2'd1) begin
            r_state      <= RESP;
            r_resp_valid <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            r_state      <= IDLE;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign resp_fault = r_resp_fault;
  assign data_out   = r_data_out;

endmodule

// File: tb/tb_data_memory_hs.sv
// Bench for data_memory_hs: three configurations driven with directed and
// random traffic, checked against a byte-array reference model.
module tb_data_memory_hs;

  localparam int DWS  [3] = '{32, 32, 64};
  localparam int LATS [3] = '{1, 3, 2};

  logic        clk;
  logic        rst_n  [3];
  logic        req_v  [3];
  logic        req_w  [3];
  logic        rsp_r  [3];
  logic [11:0] addr   [3];
  logic [63:0] din    [3];
  logic [2:0]  fn3    [3];
  logic        rr     [3];
  logic        rv     [3];
  logic        rf     [3];
  logic [63:0] dout   [3];

  // reference model state
  logic [7:0]  mem      [3][4096];
  logic        exp_rr   [3];
  logic        exp_rv   [3];
  logic        exp_zero [3];
  logic [63:0] exp_do   [3];
  logic        exp_f    [3];
  logic        armed;
  int          total;
  int          bad;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    localparam int DW = DWS[k];
    logic          w_rr, w_rv, w_rf;
    logic [DW-1:0] w_do;
    data_memory_hs #(
      .ADDR_WIDTH(12),
      .DATA_WIDTH(DW),
      .READ_LATENCY(LATS[k])
    ) u_dut (
      .clock      (clk),
      .reset_n    (rst_n[k]),
      .req_valid  (req_v[k]),
      .req_ready  (w_rr),
      .req_write  (req_w[k]),
      .address    (addr[k]),
      .data_in    (din[k][DW-1:0]),
      .funct3     (fn3[k]),
      .resp_valid (w_rv),
      .resp_ready (rsp_r[k]),
      .data_out   (w_do),
      .resp_fault (w_rf)
    );
    assign rr[k]   = w_rr;
    assign rv[k]   = w_rv;
    assign rf[k]   = w_rf;
    assign dout[k] = 64'(w_do);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int k, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d t=%0t got=%h want=%h", nm, k, $time, act, exp);
    end
  endtask

  // Architectural effect of one accepted request; returns the expected response.
  task automatic model_apply(input int k, input bit w, input logic [11:0] a, input logic [63:0] d,
                             input logic [2:0] f3, output logic [63:0] ev, output logic ef);
    int sz;
    int dw;
    sz = 1 << f3[1:0];
    dw = DWS[k];
    ef = (f3 == 3'd7) || (w && f3[2]) || (dw == 32 && (f3 == 3'd3 || f3 == 3'd6)) ||
         ((int'(a) % sz) != 0);
    ev = '0;
    if (!ef) begin
      if (w) begin
        for (int i = 0; i < sz; i++) mem[k][int'(a) + i] = d[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) ev[8*i +: 8] = mem[k][int'(a) + i];
        if (!f3[2] && (sz * 8 < dw) && ev[sz*8-1]) ev = ev | ~((64'd1 << (sz * 8)) - 64'd1);
        if (dw == 32) ev = ev & 64'hFFFF_FFFF;
      end
    end
  endtask

  // One full transaction; entered and left 1 time unit after a rising edge.
  task automatic op(input int k, input bit w, input logic [11:0] a, input logic [63:0] d,
                    input logic [2:0] f3, input int hold, output logic [63:0] got, output logic gotf);
    logic [63:0] ev;
    logic        ef;
    req_v[k] = 1'b1; req_w[k] = w; addr[k] = a; din[k] = d; fn3[k] = f3; rsp_r[k] = 1'b0;
    @(posedge clk);
    model_apply(k, w, a, d, f3, ev, ef);
    exp_rr[k] = 1'b0; exp_zero[k] = 1'b0;
    #1;
    // a request left asserted while busy must be ignored
    req_w[k] = 1'b1; fn3[k] = 3'd2; din[k] = {$urandom, $urandom};
    addr[k] = {($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00, 4'($urandom_range(0, 15)), 2'b00};
    repeat (LATS[k] - 1) @(posedge clk);
    exp_rv[k] = 1'b1; exp_do[k] = ev; exp_f[k] = ef;
    #1;
    got = dout[k]; gotf = rf[k];
    repeat (hold) @(posedge clk);
    #1 rsp_r[k] = 1'b1;
    @(posedge clk);
    exp_rv[k] = 1'b0; exp_rr[k] = 1'b1;
    #1 rsp_r[k] = 1'b0; req_v[k] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (armed) begin
      for (int k = 0; k < 3; k++) begin
        chk("req_ready", k, 64'(rr[k]), 64'(exp_rr[k]));
        chk("resp_valid", k, 64'(rv[k]), 64'(exp_rv[k]));
        if (exp_rv[k]) begin
          chk("data_out", k, dout[k], exp_do[k]);
          chk("resp_fault", k, 64'(rf[k]), 64'(exp_f[k]));
        end else if (exp_zero[k]) begin
          chk("rst_data_out", k, dout[k], 64'd0);
          chk("rst_resp_fault", k, 64'(rf[k]), 64'd0);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t got=timeout want=finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] g;
    logic        gf;
    logic [11:0] a;
    logic [2:0]  f3;
    int          nb;
    total = 0; bad = 0; armed = 1'b0;
    for (int k = 0; k < 3; k++) begin
      rst_n[k] = 1'b0; req_v[k] = 1'b0; req_w[k] = 1'b0; rsp_r[k] = 1'b0;
      addr[k] = '0; din[k] = '0; fn3[k] = '0;
      exp_rr[k] = 1'b1; exp_rv[k] = 1'b0; exp_zero[k] = 1'b1; exp_do[k] = '0; exp_f[k] = 1'b0;
    end
    repeat (2) @(posedge clk);
    #1;
    armed = 1'b1;
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(posedge clk); #1;

    // fill the low and high 64-byte windows so every model byte is known
    for (int k = 0; k < 3; k++) begin
      nb = DWS[k] / 8;
      for (int j = 0; j < 128; j += nb) begin
        a = (j < 64) ? 12'(j) : 12'(4032 + j - 64);
        op(k, 1'b1, a, {$urandom, $urandom}, (nb == 8) ? 3'd3 : 3'd2, 0, g, gf);
      end
    end

    // 32-bit, latency 1
    op(0, 1, 12'h010, 64'hDEADBEEF, 3'd2, 0, g, gf);
    op(0, 0, 12'h013, 0, 3'd0, 0, g, gf); chk("lb_13", 0, g, 64'hFFFF_FFDE);
    op(0, 0, 12'h013, 0, 3'd4, 0, g, gf); chk("lbu_13", 0, g, 64'h0000_00DE);
    op(0, 0, 12'h012, 0, 3'd5, 0, g, gf); chk("lhu_12", 0, g, 64'h0000_DEAD);
    op(0, 1, 12'h020, 64'h0, 3'd2, 0, g, gf);
    op(0, 1, 12'h022, 64'h1234, 3'd1, 0, g, gf);
    op(0, 0, 12'h020, 0, 3'd2, 0, g, gf); chk("lw_after_sh", 0, g, 64'h1234_0000);
    op(0, 1, 12'h021, 64'hAA, 3'd0, 0, g, gf);
    op(0, 0, 12'h020, 0, 3'd2, 0, g, gf); chk("lw_after_sb", 0, g, 64'h1234_AA00);
    op(0, 0, 12'h011, 0, 3'd2, 0, g, gf); chk("misalign_flt", 0, 64'(gf), 64'd1);
    chk("misalign_data", 0, g, 64'd0);
    op(0, 0, 12'h010, 0, 3'd2, 0, g, gf); chk("lw_10_intact", 0, g, 64'hDEAD_BEEF);
    op(0, 1, 12'h010, 64'h0, 3'd4, 0, g, gf); chk("sbu_illegal_flt", 0, 64'(gf), 64'd1);
    op(0, 0, 12'h010, 0, 3'd2, 0, g, gf); chk("lw_10_after_illegal", 0, g, 64'hDEAD_BEEF);

    // 32-bit, latency 3: backpressure, reset in WAIT, reset racing a request
    op(1, 1, 12'h010, 64'h11223344, 3'd2, 0, g, gf);
    op(1, 0, 12'h010, 0, 3'd2, 5, g, gf); chk("lw_held", 1, g, 64'h1122_3344);
    req_v[1] = 1; req_w[1] = 1; addr[1] = 12'h030; din[1] = 64'h55; fn3[1] = 3'd2;
    @(posedge clk);
    model_apply(1, 1'b1, 12'h030, 64'h55, 3'd2, g, gf);
    exp_rr[1] = 1'b0; exp_zero[1] = 1'b0;
    #1 req_v[1] = 0; rst_n[1] = 0;
    @(posedge clk);
    exp_rr[1] = 1'b1; exp_rv[1] = 1'b0; exp_zero[1] = 1'b1;
    #1 rst_n[1] = 1;
    @(posedge clk); #1;
    rst_n[1] = 0; req_v[1] = 1; req_w[1] = 1; addr[1] = 12'h030; din[1] = 64'h99; fn3[1] = 3'd2;
    @(posedge clk);
    #1 rst_n[1] = 1; req_v[1] = 0;
    op(1, 0, 12'h030, 0, 3'd2, 0, g, gf); chk("lw_after_reset", 1, g, 64'h55);

    // 64-bit, latency 2
    op(2, 1, 12'h008, 64'h8000_0000_0000_0001, 3'd3, 0, g, gf);
    op(2, 0, 12'h00C, 0, 3'd2, 0, g, gf); chk("lw_0c_sext", 2, g, 64'hFFFF_FFFF_8000_0000);
    op(2, 0, 12'h00C, 0, 3'd6, 0, g, gf); chk("lwu_0c", 2, g, 64'h0000_0000_8000_0000);
    op(2, 0, 12'h008, 0, 3'd3, 0, g, gf); chk("ld_08", 2, g, 64'h8000_0000_0000_0001);
    op(2, 0, 12'h00C, 0, 3'd3, 0, g, gf); chk("ld_0c_flt", 2, 64'(gf), 64'd1);

    // random traffic against the model
    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 200; n++) begin
        f3 = 3'($urandom_range(0, 7));
        a  = {($urandom_range(0, 1) == 1) ? 6'h3F : 6'h00, 6'($urandom_range(0, 63))};
        if ($urandom_range(0, 3) != 0) a = a & ~(12'(1 << f3[1:0]) - 12'd1);
        op(k, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, f3,
           ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : 0, g, gf);
      end
    end

    @(posedge clk); #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
